// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the two-master memory arbiter:
// FSM states, master identifiers and the byte-merge helper.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } master_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    // Bytes with their enable set come from the new word, the rest from the old one.
    function automatic logic [31:0] merge_bytes(input logic [31:0] new_word,
                                                input logic [31:0] old_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester arbiter with a preference pointer. Round-robin when
// MEM_ARBITER_RR_EN is defined, otherwise the pointer stays on m0 (fixed priority).
import riscv_mem_pkg::*;

module arb_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output master_t    gnt_id
);

    master_t prefer;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = MST_M0;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt_id = prefer;
            end else if (req[1]) begin
                gnt_id = MST_M1;
            end else begin
                gnt_id = MST_M0;
            end
            if (req != 2'b00) begin
                gnt[gnt_id] = 1'b1;
            end
        end
    end

    // The pointer only moves when a grant is actually issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer <= MST_M0;
        end else if (en && (req != 2'b00)) begin
`ifdef MEM_ARBITER_RR_EN
            prefer <= (gnt_id == MST_M0) ? MST_M1 : MST_M0;
`else
            prefer <= MST_M0;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port memory arbiter with read-modify-write for partial
// byte-enable writes. Define MEM_ARBITER_RR_EN for round-robin arbitration.
import riscv_mem_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_next;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cap_q;
    logic [3:0]        be_q;
    master_t           grant_q;
    logic [1:0]        gnt;
    master_t           gnt_id;
    logic              arb_en;
    logic              accept;
    logic              unused_addr_bits;

    // Gating with reset keeps both readies low while reset is held.
    assign arb_en = (state == IDLE) && !reset;
    assign accept = (gnt != 2'b00);

    arb_rr2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .req    ({m1_req_valid, m0_req_valid}),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign m0_req_ready = gnt[0];
    assign m1_req_ready = gnt[1];
    assign m0_rsp_valid = (state == RESP) && (grant_q == MST_M0);
    assign m1_rsp_valid = (state == RESP) && (grant_q == MST_M1);

    assign mem_addr         = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata        = (state == MERGE) ? merge_bytes(wdata_q, cap_q, be_q) : wdata_q;
    assign unused_addr_bits = ^addr_q[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Partial writes detour through MERGE; empty byte-enable writes never touch memory.
    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q && (be_q != BE_FULL) && (be_q != 4'h0)) begin
                    state_next = MERGE;
                end else begin
                    mem_we     = we_q && (be_q == BE_FULL);
                    state_next = RESP;
                end
            end
            MERGE: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= 4'h0;
            grant_q  <= MST_M0;
            cap_q    <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (accept) begin
                grant_q <= gnt_id;
                if (gnt_id == MST_M1) begin
                    we_q    <= m1_we;
                    addr_q  <= m1_addr;
                    wdata_q <= m1_wdata;
                    be_q    <= m1_be;
                end else begin
                    we_q    <= m0_we;
                    addr_q  <= m0_addr;
                    wdata_q <= m0_wdata;
                    be_q    <= m0_be;
                end
            end
            if (state == ACCESS) begin
                cap_q <= mem_rdata;
                if (grant_q == MST_M1) begin
                    m1_rdata <= we_q ? '0 : mem_rdata;
                end else begin
                    m0_rdata <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small word memory model;
// expectations follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req_valid, m0_req_ready, m0_we, m0_rsp_valid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req_valid, m1_req_ready, m1_we, m1_rsp_valid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [64];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;
    int          wr_count;
    logic        unused_mem_addr_bits;

    int nchk;
    int npass;
    int nfail;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_be        (m0_be),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rdata     (m0_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_be        (m1_be),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rdata     (m1_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata            = mem[mem_addr[7:2]];
    assign unused_mem_addr_bits = ^{mem_addr[31:8], mem_addr[1:0]};

    // Memory model: preload port for the bench, write port for the DUT.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_count           <= wr_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nchk++;
        assert (observed === expected) npass++;
        else begin
            nfail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx[5:0];
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // One transaction from one master; exp_we_cyc is the cycle after accept with mem_we high (0 = never).
    task automatic applyStimulus(input string tag, input bit mst, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int exp_lat,
                                 input int exp_we_cyc, input logic [31:0] exp_rdata);
        int          lat;
        int          we_cyc;
        int          we_n;
        int          wr_start;
        logic        other_rsp;
        logic [31:0] got_rdata;
        @(negedge clk);
        wr_start = wr_count;
        if (mst) begin
            m1_req_valid = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end else begin
            m0_req_valid = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end
        #1;
        checkOutput({tag, ".ready"}, {31'b0, mst ? m1_req_ready : m0_req_ready}, 32'd1);
        checkOutput({tag, ".other_ready"}, {31'b0, mst ? m0_req_ready : m1_req_ready}, 32'd0);
        lat = 0; we_cyc = 0; we_n = 0; other_rsp = 1'b0; got_rdata = 32'hX;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            m0_req_valid = 1'b0;
            m1_req_valid = 1'b0;
            #1;
            if (mem_we) begin
                we_n++;
                if (we_cyc == 0) we_cyc = k;
            end
            if (mst ? m0_rsp_valid : m1_rsp_valid) other_rsp = 1'b1;
            if (mst ? m1_rsp_valid : m0_rsp_valid) begin
                lat       = k;
                got_rdata = mst ? m1_rdata : m0_rdata;
            end
        end
        checkOutput({tag, ".latency"}, lat, exp_lat);
        checkOutput({tag, ".rdata"}, got_rdata, exp_rdata);
        checkOutput({tag, ".we_cycle"}, we_cyc, exp_we_cyc);
        checkOutput({tag, ".we_pulses"}, we_n, (exp_we_cyc != 0) ? 1 : 0);
        checkOutput({tag, ".other_rsp"}, {31'b0, other_rsp}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, ".rsp_drop"}, {31'b0, mst ? m1_rsp_valid : m0_rsp_valid}, 32'd0);
        checkOutput({tag, ".rdata_hold"}, mst ? m1_rdata : m0_rdata, exp_rdata);
        checkOutput({tag, ".mem_writes"}, wr_count - wr_start, (exp_we_cyc != 0) ? 1 : 0);
    endtask

    initial begin
        int   grants[8];
        int   ng;
        int   m1_ready_cnt;
        logic both_ready;
        int   exp_g[4];
        int   exp_m1_cnt;
        int   wr_start;
        logic rsp_seen;

        nchk = 0; npass = 0; nfail = 0;
        wr_count = 0;
        pre_en = 1'b0; pre_idx = 6'd0; pre_val = 32'd0;
        reset = 1'b1;
        m0_req_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0; m0_be = 4'hF;
        m1_req_valid = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;  m1_wdata = 32'h0; m1_be = 4'hF;

        // Reset state, with a request pending that must not be accepted.
        @(negedge clk);
        #1;
        checkOutput("reset.m0_ready", {31'b0, m0_req_ready}, 32'd0);
        checkOutput("reset.m1_ready", {31'b0, m1_req_ready}, 32'd0);
        checkOutput("reset.mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset.m0_rsp", {31'b0, m0_rsp_valid}, 32'd0);
        checkOutput("reset.m1_rsp", {31'b0, m1_rsp_valid}, 32'd0);
        checkOutput("reset.m0_rdata", m0_rdata, 32'd0);
        checkOutput("reset.m1_rdata", m1_rdata, 32'd0);
        m0_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        preload(4, 32'hDEADBEEF);
        applyStimulus("rd_m0", 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 2, 0, 32'hDEADBEEF);

        applyStimulus("wr_full_m1", 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 2, 1, 32'h0);
        checkOutput("wr_full_m1.mem8", mem[8], 32'h12345678);

        preload(8, 32'h11223344);
        applyStimulus("wr_part_m0", 1'b0, 1'b1, 32'h21, 32'h0000AB00, 4'b0010, 3, 2, 32'h0);
        checkOutput("wr_part_m0.mem8", mem[8], 32'h1122AB44);

        preload(12, 32'h55AA55AA);
        applyStimulus("wr_be0_m1", 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 2, 0, 32'h0);
        checkOutput("wr_be0_m1.mem12", mem[12], 32'h55AA55AA);

        applyStimulus("rd_m1", 1'b1, 1'b0, 32'h22, 32'h0, 4'hF, 2, 0, 32'h1122AB44);

        // Reset lands in the ACCESS cycle of a full write: the write must be dropped.
        @(negedge clk);
        wr_start = wr_count;
        m1_req_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hCAFEF00D; m1_be = 4'hF;
        #1;
        checkOutput("abort.ready", {31'b0, m1_req_ready}, 32'd1);
        @(negedge clk);
        m1_req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("abort.mem_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rsp_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (m0_rsp_valid || m1_rsp_valid || mem_we) rsp_seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort.no_activity", {31'b0, rsp_seen}, 32'd0);
        checkOutput("abort.mem_writes", wr_count - wr_start, 32'd0);
        checkOutput("abort.mem8", mem[8], 32'h1122AB44);

`ifdef MEM_ARBITER_RR_EN
        exp_g = '{0, 1, 0, 1};
        exp_m1_cnt = 2;
`else
        exp_g = '{0, 0, 0, 0};
        exp_m1_cnt = 0;
`endif
        // Both masters request continuously for four back-to-back reads.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m0_req_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_be = 4'hF;
        m1_req_valid = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_be = 4'hF;
        ng = 0; m1_ready_cnt = 0; both_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m0_req_ready && m1_req_ready) both_ready = 1'b1;
            if (m1_req_ready) m1_ready_cnt++;
            if ((m0_req_ready || m1_req_ready) && ng < 8) begin
                grants[ng] = m1_req_ready ? 1 : 0;
                ng++;
            end
            @(negedge clk);
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        checkOutput("arb.grant_count", ng, 32'd4);
        checkOutput("arb.both_ready", {31'b0, both_ready}, 32'd0);
        checkOutput("arb.m1_ready_cycles", m1_ready_cnt, exp_m1_cnt);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("arb.grant%0d", i), (i < ng) ? grants[i] : -1, exp_g[i]);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
